// File: rtl/scan_mux_nx1.sv
// scan_mux_nx1 -- N-channel, W-bit registered multiplexer with valid/ready output.
// The channel comes either from a manual select (MANUAL) or from an internal
// round-robin pointer that dwells DWELL samples on each channel (SCAN).
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   din        N*W packed channels, channel k at din[k*W +: W]
//   sel        manual channel select
//   mode       0 = MANUAL, 1 = SCAN
//   en         sample request
//   out_ready  downstream accepts dout this cycle
//   dout       registered selected sample
//   out_ch     channel index dout was taken from
//   out_valid  dout/out_ch valid
//   wrap       1-cycle pulse when the scan pointer wraps N-1 -> 0
module scan_mux_nx1 #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SW    = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0] sel,
  input  logic          mode,
  input  logic          en,
  input  logic          out_ready,
  output logic [W-1:0]  dout,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  output logic          wrap
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   NCH   = (SW+1)'(N);
  localparam logic [SW-1:0] PLAST = SW'(N-1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL-1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t        r_state;
  logic [SW-1:0] r_ptr;
  logic [DW-1:0] r_dcnt;
  logic [W-1:0]  r_dout;
  logic [SW-1:0] r_ch;
  logic          r_valid;
  logic          r_wrap;

  logic          w_scan;
  logic          w_trans;
  logic          w_bad;
  logic          w_load;
  logic [SW-1:0] w_ch;
  logic [W-1:0]  w_data;

  always_comb begin
    w_scan  = (r_state == SCAN);
    // State lags mode by one cycle; the cycle it catches up never loads.
    w_trans = (w_scan != mode);
    w_bad   = !w_scan && ({1'b0, sel} >= NCH);
    w_ch    = w_scan ? r_ptr : sel;
    w_load  = en && (!r_valid || out_ready) && !w_trans && !w_bad;
    // Out-of-range channels select zero so the mux never produces X.
    w_data  = '0;
    for (int k = 0; k < N; k++)
      if (w_ch == SW'(k)) w_data = din[k*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MANUAL;
      r_ptr   <= '0;
      r_dcnt  <= '0;
      r_dout  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_trans) begin
        r_state <= mode ? SCAN : MANUAL;
        if (mode) begin
          r_ptr  <= '0;
          r_dcnt <= '0;
        end
      end
      if (w_load) begin
        r_dout  <= w_data;
        r_ch    <= w_ch;
        r_valid <= 1'b1;
        if (w_scan) begin
          if (r_dcnt == DLAST) begin
            r_dcnt <= '0;
            r_ptr  <= (r_ptr == PLAST) ? '0 : r_ptr + 1'b1;
            r_wrap <= (r_ptr == PLAST);
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout      = r_dout;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;
  assign wrap      = r_wrap;

endmodule
